riscv_lsu: RTL and testbench

Load-store unit that consumes the memory-control outputs of riscv_decoder (mem_req, mem_we, mem_size) together with the ALU address and rs2 data. It converts each core access into a single word-aligned data-memory transaction with byte enables. It stalls the core until the memory answers, then returns sign- or zero-extended load data for the WB_LSU_DATA writeback path. It sits between the core datapath and the data memory/bus.

---
 rtl/riscv_lsu.sv | 242 ++++++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// ---------------------------------------------------------------------------
// riscv_lsu -- load-store unit between the core datapath and data memory.
//
// Turns one core access (decoder mem_req/mem_we/mem_size, ALU address and
// rs2 data) into a single word-aligned memory transaction with byte enables.
// The core is stalled until memory answers; load data comes back sign- or
// zero-extended for the LSU writeback path.
//
// Build option:
//   MISALIGN_EXC_EN  when defined, misaligned halfword/word accesses are not
//                    sent to memory and raise a one-cycle misaligned_o pulse.
//                    When undefined, misaligned_o is tied 0 and the low
//                    address bits are simply ignored for H/W accesses.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   core_req_i          access request
//   core_we_i           1 = store, 0 = load
//   core_size_i         B=0, H=1, W=2, BU=4, HU=5 (3/6/7 behave as W)
//   core_addr_i         byte address
//   core_wd_i           store data
//   core_rd_o           extended load data (registered)
//   core_stall_req_o    hold the pipeline while 1 (combinational)
//   misaligned_o        misaligned-access pulse
//   mem_req_o           memory request
//   mem_we_o            memory write enable
//   mem_be_o            byte enables
//   mem_addr_o          word-aligned memory address
//   mem_wd_o            lane-replicated store data
//   mem_rd_i            memory read word
//   mem_ready_i         memory completes the request this cycle
//
// States:
//   state   | meaning
//   IDLE    | waiting for a core request; stall follows core_req_i
//   REQ     | memory request outstanding; stall held high
//   DONE    | one-cycle retire slot; stall released, no request
// ---------------------------------------------------------------------------
module riscv_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [2:0]            core_size_i,
    input  logic [ADDR_W-1:0]     core_addr_i,
    input  logic [DATA_W-1:0]     core_wd_i,
    output logic [DATA_W-1:0]     core_rd_o,
    output logic                  core_stall_req_o,
    output logic                  misaligned_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wd_o,
    input  logic [DATA_W-1:0]     mem_rd_i,
    input  logic                  mem_ready_i
);

    localparam int BE_W = DATA_W / 8;

    // Any size code other than these four is treated as a full word.
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;
    logic [DATA_W-1:0]   core_rd_q, core_rd_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          off_q, off_d;
`ifdef MISALIGN_EXC_EN
    logic                misaligned_q, misaligned_d;
`endif

    logic                req_byte;
    logic                req_half;
    logic                req_misaligned;
    logic [BE_W-1:0]     st_be;
    logic [DATA_W-1:0]   st_wd;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_W-1:0]   ld_data;

    // Store formatting from the live core inputs; captured on the request.
    always_comb begin
        req_byte = (core_size_i == LDST_B) || (core_size_i == LDST_BU);
        req_half = (core_size_i == LDST_H) || (core_size_i == LDST_HU);
        st_be    = '1;
        st_wd    = core_wd_i;
        if (req_byte) begin
            st_be = 4'b0001 << core_addr_i[1:0];
            st_wd = {4{core_wd_i[7:0]}};
        end else if (req_half) begin
            st_be = 4'b0011 << {core_addr_i[1], 1'b0};
            st_wd = {2{core_wd_i[15:0]}};
        end
    end

`ifdef MISALIGN_EXC_EN
    assign req_misaligned = (req_half && core_addr_i[0]) ||
                            (!req_byte && !req_half && (core_addr_i[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    // Load formatting uses the latched size/offset so that core inputs
    // changing during the wait cannot corrupt the returned value.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rd_i[7:0];
            2'd1:    ld_byte = mem_rd_i[15:8];
            2'd2:    ld_byte = mem_rd_i[23:16];
            default: ld_byte = mem_rd_i[31:24];
        endcase
        ld_half = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_q)
            LDST_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            LDST_BU: ld_data = {24'd0, ld_byte};
            LDST_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            LDST_HU: ld_data = {16'd0, ld_half};
            default: ld_data = mem_rd_i;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        mem_req_d        = mem_req_q;
        mem_we_d         = mem_we_q;
        mem_be_d         = mem_be_q;
        mem_addr_d       = mem_addr_q;
        mem_wd_d         = mem_wd_q;
        core_rd_d        = core_rd_q;
        size_d           = size_q;
        off_d            = off_q;
`ifdef MISALIGN_EXC_EN
        misaligned_d     = 1'b0;
`endif
        core_stall_req_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                core_stall_req_o = core_req_i;
                if (core_req_i) begin
                    if (req_misaligned) begin
                        // Trapped access: skip memory, retire straight away.
                        state_d = ST_DONE;
`ifdef MISALIGN_EXC_EN
                        misaligned_d = 1'b1;
`endif
                    end else begin
                        state_d    = ST_REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = core_we_i;
                        mem_be_d   = core_we_i ? st_be : '1;
                        mem_addr_d = {core_addr_i[ADDR_W-1:2], 2'b00};
                        mem_wd_d   = st_wd;
                        size_d     = core_size_i;
                        off_d      = core_addr_i[1:0];
                    end
                end
            end

            ST_REQ: begin
                core_stall_req_o = 1'b1;
                if (mem_ready_i) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        core_rd_d = ld_data;
                    end
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // A request seen here belongs to the next instruction and is
                // picked up from IDLE on the following cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            core_rd_q    <= '0;
            size_q       <= 3'd0;
            off_q        <= 2'd0;
`ifdef MISALIGN_EXC_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            core_rd_q    <= core_rd_d;
            size_q       <= size_d;
            off_q        <= off_d;
`ifdef MISALIGN_EXC_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_be_o   = mem_be_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_wd_o   = mem_wd_q;
    assign core_rd_o  = core_rd_q;
`ifdef MISALIGN_EXC_EN
    assign misaligned_o = misaligned_q;
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// ---------------------------------------------------------------------------
// tb_riscv_lsu -- self-checking bench for riscv_lsu.
// Expected values come from a small arithmetic model of the access rules.
// ---------------------------------------------------------------------------
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'd0;
    logic [31:0] core_wd_i = 32'd0;
    logic [31:0] core_rd_o;
    logic        core_stall_req_o;
    logic        misaligned_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = 32'd0;
    logic        mem_ready_i = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_rd = 32'd0;

`ifdef MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .core_req_i       (core_req_i),
        .core_we_i        (core_we_i),
        .core_size_i      (core_size_i),
        .core_addr_i      (core_addr_i),
        .core_wd_i        (core_wd_i),
        .core_rd_o        (core_rd_o),
        .core_stall_req_o (core_stall_req_o),
        .misaligned_o     (misaligned_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_be_o         (mem_be_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wd_o         (mem_wd_o),
        .mem_rd_i         (mem_rd_i),
        .mem_ready_i      (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic bit m_is_byte(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd4);
    endfunction

    function automatic bit m_is_half(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd5);
    endfunction

    function automatic bit m_mis(input logic [2:0] s, input logic [31:0] a);
        if (!MIS_EN) return 1'b0;
        if (m_is_byte(s)) return 1'b0;
        if (m_is_half(s)) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] m_be(input bit we, input logic [2:0] s, input logic [31:0] a);
        int n, base;
        if (!we) return 4'hF;
        if (m_is_byte(s)) begin
            n = 1; base = int'(a % 4);
        end else if (m_is_half(s)) begin
            n = 2; base = int'((a % 4) / 2) * 2;
        end else begin
            n = 4; base = 0;
        end
        return 4'(((1 << n) - 1) << base);
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
        if (m_is_byte(s)) return (wd & 32'hFF) * 32'h0101_0101;
        if (m_is_half(s)) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        if (m_is_byte(s)) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (s == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (m_is_half(s)) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (s == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- access driver (collects observations only) ----------------
    task automatic do_access(
        input  bit          we,
        input  logic [2:0]  size,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  logic [31:0] rdv,
        input  int          waits,
        input  bit          hold_req,
        input  bit          churn,
        output int          stall_cnt,
        output int          req_cnt,
        output logic [31:0] o_addr,
        output logic [31:0] o_wd,
        output logic [3:0]  o_be,
        output logic        o_we,
        output bit          stable,
        output logic [31:0] o_rd,
        output int          mis_cnt,
        output bit          req_at_start,
        output bit          done_seen
    );
        bit done;
        stall_cnt = 0; req_cnt = 0; o_addr = 0; o_wd = 0; o_be = 0; o_we = 0;
        stable = 1'b1; o_rd = 0; mis_cnt = 0; req_at_start = 1'b0; done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk_i); #1;
            if (k == 0) begin
                core_req_i  = 1'b1;
                core_we_i   = we;
                core_size_i = size;
                core_addr_i = addr;
                core_wd_i   = wd;
            end else begin
                core_req_i = hold_req;
                if (churn) begin
                    core_we_i   = 1'($urandom_range(0, 1));
                    core_size_i = 3'($urandom_range(0, 7));
                    core_addr_i = $urandom;
                    core_wd_i   = $urandom;
                end
            end
            if (mem_req_o) begin
                mem_ready_i = (req_cnt == waits);
                mem_rd_i    = (req_cnt == waits) ? rdv : $urandom;
            end else begin
                mem_ready_i = churn ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rd_i    = $urandom;
            end
            @(negedge clk_i);
            if (core_stall_req_o) stall_cnt++;
            if (misaligned_o) mis_cnt++;
            if (k == 0) req_at_start = mem_req_o;
            if (mem_req_o) begin
                if (req_cnt == 0) begin
                    o_addr = mem_addr_o; o_wd = mem_wd_o; o_be = mem_be_o; o_we = mem_we_o;
                end else if (o_addr !== mem_addr_o || o_wd !== mem_wd_o ||
                             o_be !== mem_be_o || o_we !== mem_we_o) begin
                    stable = 1'b0;
                end
                req_cnt++;
            end
            if (k > 0 && !core_stall_req_o) begin
                done = 1'b1;
                o_rd = core_rd_o;
            end
        end
        done_seen   = done;
        mem_ready_i = 1'b0;
    endtask

    // observation variables shared by the test tasks (one process only)
    int          ob_stall, ob_req, ob_mis;
    logic [31:0] ob_addr, ob_wd, ob_rd;
    logic [3:0]  ob_be;
    logic        ob_we;
    bit          ob_stable, ob_req0, ob_done;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        core_req_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rd_i = $urandom;
        end
        @(negedge clk_i);
        tests_run++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !== 70'd0) begin
            tests_failed++;
            $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wd=%h expected all zero",
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o);
        end
        tests_run++;
        if (core_rd_o !== 32'd0 || misaligned_o !== 1'b0 || core_stall_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_core: got rd=%h mis=%b stall=%b expected 0/0/0",
                     core_rd_o, misaligned_o, core_stall_req_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        mem_ready_i = 1'b0;
        exp_rd = 32'd0;
    endtask

    task automatic test_load_signed_byte();
        do_access(1'b0, 3'd0, 32'h103, 32'h5555_5555, 32'h80FF_7F01, 0, 1'b0, 1'b0,
                  ob_stall, ob_req, ob_addr, ob_wd, ob_be, ob_we, ob_stable, ob_rd,
                  ob_mis, ob_req0, ob_done);
        core_req_i = 1'b0;
        exp_rd = 32'hFFFF_FF80;
        tests_run++;
        if (!ob_done || ob_rd !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("FAIL lb_data: got %h done=%0d expected ffffff80", ob_rd, ob_done);
        end
        tests_run++;
        if (ob_addr !== 32'h100 || ob_be !== 4'hF || ob_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL lb_bus: got addr=%h be=%h we=%b expected 100/f/0", ob_addr, ob_be, ob_we);
        end
        tests_run++;
        if (ob_stall != 2 || ob_req != 1) begin
            tests_failed++;
            $display("FAIL lb_latency: got stall=%0d req=%0d expected 2/1", ob_stall, ob_req);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  sz  [3] = '{3'd4, 3'd5, 3'd1};
        logic [31:0] exv [3] = '{32'h0000_0001, 32'h0000_8001, 32'hFFFF_8001};
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, sz[i], 32'h102, 32'h0, 32'h8001_0000, 0, 1'b0, 1'b0,
                      ob_stall, ob_req, ob_addr, ob_wd, ob_be, ob_we, ob_stable, ob_rd,
                      ob_mis, ob_req0, ob_done);
            core_req_i = 1'b0;
            exp_rd = exv[i];
            tests_run++;
            if (!ob_done || ob_rd !== exv[i]) begin
                tests_failed++;
                $display("FAIL load_ext size=%0d: got %h expected %h", sz[i], ob_rd, exv[i]);
            end
        end
    endtask

    task automatic test_store_half();
        do_access(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 1'b0, 1'b0,
                  ob_stall, ob_req, ob_addr, ob_wd, ob_be, ob_we, ob_stable, ob_rd,
                  ob_mis, ob_req0, ob_done);
        core_req_i = 1'b0;
        tests_run++;
        if (ob_we !== 1'b1 || ob_be !== 4'b1100 || ob_wd !== 32'hABCD_ABCD || ob_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL sh_bus: got we=%b be=%b wd=%h addr=%h expected 1/1100/abcdabcd/200",
                     ob_we, ob_be, ob_wd, ob_addr);
        end
        tests_run++;
        if (!ob_done || ob_rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL sh_rd_kept: got %h expected %h", ob_rd, exp_rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rdv;
        rdv = $urandom;
        do_access(1'b0, 3'd1, 32'h0000_0106, 32'h0, rdv, 3, 1'b0, 1'b1,
                  ob_stall, ob_req, ob_addr, ob_wd, ob_be, ob_we, ob_stable, ob_rd,
                  ob_mis, ob_req0, ob_done);
        core_req_i = 1'b0;
        exp_rd = m_load(3'd1, 32'h106, rdv);
        tests_run++;
        if (ob_stall != 5 || ob_req != 4) begin
            tests_failed++;
            $display("FAIL wait_latency: got stall=%0d req=%0d expected 5/4", ob_stall, ob_req);
        end
        tests_run++;
        if (!ob_stable || ob_addr !== 32'h104 || ob_be !== 4'hF || ob_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_stable: got stable=%0d addr=%h be=%h we=%b expected 1/104/f/0",
                     ob_stable, ob_addr, ob_be, ob_we);
        end
        tests_run++;
        if (!ob_done || ob_rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL wait_data: got %h expected %h", ob_rd, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdv;
        rdv = $urandom;
        do_access(1'b0, 3'd0, 32'h0000_0011, 32'h0, rdv, 0, 1'b1, 1'b0,
                  ob_stall, ob_req, ob_addr, ob_wd, ob_be, ob_we, ob_stable, ob_rd,
                  ob_mis, ob_req0, ob_done);
        exp_rd = m_load(3'd0, 32'h11, rdv);
        tests_run++;
        if (!ob_done || ob_stall != 2 || ob_rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL b2b_first: got done=%0d stall=%0d rd=%h expected 1/2/%h",
                     ob_done, ob_stall, ob_rd, exp_rd);
        end
        do_access(1'b1, 3'd2, 32'h0000_0024, 32'hCAFE_0123, 32'h0, 1, 1'b0, 1'b0,
                  ob_stall, ob_req, ob_addr, ob_wd, ob_be, ob_we, ob_stable, ob_rd,
                  ob_mis, ob_req0, ob_done);
        core_req_i = 1'b0;
        tests_run++;
        if (ob_req0 !== 1'b0 || ob_stall != 3 || ob_req != 2) begin
            tests_failed++;
            $display("FAIL b2b_second: got req_at_idle=%b stall=%0d req=%0d expected 0/3/2",
                     ob_req0, ob_stall, ob_req);
        end
        tests_run++;
        if (ob_addr !== 32'h24 || ob_be !== 4'hF || ob_wd !== 32'hCAFE_0123 || ob_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_bus: got addr=%h be=%h wd=%h we=%b expected 24/f/cafe0123/1",
                     ob_addr, ob_be, ob_wd, ob_we);
        end
    endtask

    task automatic test_reset_in_req();
        logic was_req;
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h400;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        rst_i = 1'b1;
        was_req = mem_req_o;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        exp_rd = 32'd0;
        tests_run++;
        if (was_req !== 1'b1 || mem_req_o !== 1'b0 || core_stall_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_in_req: got req_before=%b req=%b stall=%b expected 1/0/0",
                     was_req, mem_req_o, core_stall_req_o);
        end
        tests_run++;
        if (core_rd_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_in_req_rd: got %h expected 0", core_rd_o);
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  sz [2] = '{3'd2, 3'd1};
        logic [31:0] ad [2] = '{32'h301, 32'h203};
        bit          wev[2] = '{1'b0, 1'b1};
        bit          m;
        for (int i = 0; i < 2; i++) begin
            m = m_mis(sz[i], ad[i]);
            do_access(wev[i], sz[i], ad[i], 32'h0000_BEEF, 32'hCAFE_F00D, 0, 1'b0, 1'b0,
                      ob_stall, ob_req, ob_addr, ob_wd, ob_be, ob_we, ob_stable, ob_rd,
                      ob_mis, ob_req0, ob_done);
            core_req_i = 1'b0;
            if (!m && !wev[i]) exp_rd = m_load(sz[i], ad[i], 32'hCAFE_F00D);
            tests_run++;
            if (ob_stall != (m ? 1 : 2) || ob_req != (m ? 0 : 1) || ob_mis != (m ? 1 : 0)) begin
                tests_failed++;
                $display("FAIL misalign_%0d: got stall=%0d req=%0d mis=%0d expected %0d/%0d/%0d",
                         i, ob_stall, ob_req, ob_mis, m ? 1 : 2, m ? 0 : 1, m ? 1 : 0);
            end
            tests_run++;
            if (!ob_done || ob_rd !== exp_rd ||
                ob_addr !== (m ? 32'h0 : (ad[i] & 32'hFFFF_FFFC)) ||
                ob_be !== (m ? 4'h0 : m_be(wev[i], sz[i], ad[i]))) begin
                tests_failed++;
                $display("FAIL misalign_res_%0d: got rd=%h addr=%h be=%h expected rd=%h",
                         i, ob_rd, ob_addr, ob_be, exp_rd);
            end
        end
    endtask

    task automatic test_random();
        bit          we, m;
        logic [2:0]  sz;
        logic [31:0] ad, wd, rdv;
        int          waits;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            ad = $urandom;
            wd = $urandom;
            rdv = $urandom;
            waits = $urandom_range(0, 3);
            m = m_mis(sz, ad);
            do_access(we, sz, ad, wd, rdv, waits, 1'b0, 1'b1,
                      ob_stall, ob_req, ob_addr, ob_wd, ob_be, ob_we, ob_stable, ob_rd,
                      ob_mis, ob_req0, ob_done);
            core_req_i = 1'b0;
            if (!m && !we) exp_rd = m_load(sz, ad, rdv);
            tests_run++;
            if (!ob_done || ob_stall != (m ? 1 : 2 + waits) || ob_req != (m ? 0 : 1 + waits) ||
                ob_mis != (m ? 1 : 0) || !ob_stable) begin
                tests_failed++;
                $display("FAIL rand_%0d_timing: got done=%0d stall=%0d req=%0d mis=%0d stable=%0d waits=%0d mis_exp=%0d",
                         i, ob_done, ob_stall, ob_req, ob_mis, ob_stable, waits, m);
            end
            tests_run++;
            if (ob_rd !== exp_rd) begin
                tests_failed++;
                $display("FAIL rand_%0d_rd: got %h expected %h (we=%0d size=%0d addr=%h)",
                         i, ob_rd, exp_rd, we, sz, ad);
            end
            if (!m) begin
                tests_run++;
                if (ob_addr !== (ad & 32'hFFFF_FFFC) || ob_be !== m_be(we, sz, ad) ||
                    ob_we !== we || (we && ob_wd !== m_wd(sz, wd))) begin
                    tests_failed++;
                    $display("FAIL rand_%0d_bus: got addr=%h be=%h we=%b wd=%h expected %h/%h/%b/%h",
                             i, ob_addr, ob_be, ob_we, ob_wd, ad & 32'hFFFF_FFFC,
                             m_be(we, sz, ad), we, m_wd(sz, wd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_signed_byte();
        test_load_ext();
        test_store_half();
        test_wait_states();
        test_back_to_back();
        test_reset_in_req();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
